// File: rtl/cpu_inst_encoder_if.sv
// Request channel and instruction-memory write channel of the LEGv8 encoder.
// The master issues symbolic requests; the slave (encoder) drives memory writes.
`timescale 1ns/1ps
interface cpu_inst_encoder_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [25:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, op_sel, rd, rn, rm, imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, op_sel, rd, rn, rm, imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/cpu_inst_encoder.sv
// Sequential LEGv8 instruction encoder: turns symbolic requests into 32-bit words
// and writes them to consecutive instruction-memory addresses starting at 0.
`timescale 1ns/1ps
module cpu_inst_encoder #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    cpu_inst_encoder_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [1:0] {StIdle, StLoad, StDone, StFull} state_e;

    localparam logic [ADDR_W-1:0] WpLast = '1;
    localparam logic [3:0]        OpHalt = 4'd10;

    state_e            state_q;
    logic [ADDR_W-1:0] wp_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              we_q;
    logic              done_q;
    logic              err_q;

    logic        xfer;
    logic        op_ok;
    logic [31:0] word;

    assign bus.in_ready   = (state_q == StLoad) && !start;
    assign xfer           = bus.in_valid && bus.in_ready;
    assign op_ok          = (bus.op_sel <= OpHalt);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q == StLoad);
    assign done           = done_q;
    assign err            = err_q;
    assign count          = count_q;

    always_comb begin
        word = '0;
        case (bus.op_sel)
            4'd0:  word = {11'b11111000010, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
            4'd1:  word = {11'b11111000000, bus.imm[8:0], 2'b00, bus.rn, bus.rd};
            4'd2:  word = {11'b10001011000, bus.rm, 6'b0, bus.rn, bus.rd};
            4'd3:  word = {10'b1001000100, bus.imm[11:0], bus.rn, bus.rd};
            4'd4:  word = {11'b11001011000, bus.rm, 6'b0, bus.rn, bus.rd};
            4'd5:  word = {11'b10001010000, bus.rm, 6'b0, bus.rn, bus.rd};
            4'd6:  word = {11'b10101010000, bus.rm, 6'b0, bus.rn, bus.rd};
            4'd7:  word = {8'b10110100, bus.imm[18:0], bus.rd};
            4'd8:  word = {8'b10110101, bus.imm[18:0], bus.rd};
            4'd9:  word = {6'b000101, bus.imm[25:0]};
            4'd10: word = 32'hFFE0_0000;
            default: word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wp_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (start) begin
            state_q <= StLoad;
            wp_q    <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            // A request presented while full is dropped and flagged.
            if (state_q == StFull && bus.in_valid) begin
                err_q <= 1'b1;
            end
            if (xfer) begin
                if (op_ok) begin
                    we_q    <= 1'b1;
                    addr_q  <= wp_q;
                    wdata_q <= word;
                    wp_q    <= wp_q + 1'b1;
                    count_q <= count_q + 1'b1;
                    if (bus.op_sel == OpHalt) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (wp_q == WpLast) begin
                        state_q <= StFull;
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_inst_encoder.sv
// Directed bench for cpu_inst_encoder: a 64-word instance for encodings and control,
// and a 4-word instance for the full / halt-at-last-address corners.
`timescale 1ns/1ps
module tb_cpu_inst_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic       busy_a, done_a, err_a;
    logic       busy_b, done_b, err_b;
    logic [6:0] count_a;
    logic [2:0] count_b;

    cpu_inst_encoder_if #(.ADDR_W(6)) bus_a ();
    cpu_inst_encoder_if #(.ADDR_W(2)) bus_b ();

    cpu_inst_encoder #(.ADDR_W(6)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_a),
        .bus   (bus_a),
        .busy  (busy_a),
        .done  (done_a),
        .err   (err_a),
        .count (count_a)
    );

    cpu_inst_encoder #(.ADDR_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_b),
        .bus   (bus_b),
        .busy  (busy_b),
        .done  (done_b),
        .err   (err_b),
        .count (count_b)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [25:0] imm;
        logic        we;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[14];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [25:0] imm);
        bus_a.in_valid = 1'b1;
        bus_a.op_sel   = op;
        bus_a.rd       = rd;
        bus_a.rn       = rn;
        bus_a.rm       = rm;
        bus_a.imm      = imm;
    endtask

    task automatic drive_b(input logic [3:0] op, input logic [4:0] rd);
        bus_b.in_valid = 1'b1;
        bus_b.op_sel   = op;
        bus_b.rd       = rd;
        bus_b.rn       = 5'd1;
        bus_b.rm       = 5'd2;
        bus_b.imm      = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_addr;
        logic        exp_err;
        logic [31:0] last_word;

        vecs[0]  = '{4'd2,  5'd3,  5'd1,  5'd2,  26'd0,        1'b1, 32'h8B02_0023};
        vecs[1]  = '{4'd0,  5'd5,  5'd2,  5'd0,  26'd8,        1'b1, 32'hF840_8045};
        vecs[2]  = '{4'd3,  5'd1,  5'd0,  5'd0,  26'd1,        1'b1, 32'h9100_0401};
        vecs[3]  = '{4'd7,  5'd9,  5'd0,  5'd0,  26'd3,        1'b1, 32'hB400_0069};
        vecs[4]  = '{4'd9,  5'd0,  5'd0,  5'd0,  26'h3FFFFFE,  1'b1, 32'h17FF_FFFE};
        vecs[5]  = '{4'd4,  5'd4,  5'd5,  5'd6,  26'd0,        1'b1, 32'hCB06_00A4};
        vecs[6]  = '{4'd12, 5'd1,  5'd1,  5'd1,  26'd0,        1'b0, 32'h0};
        vecs[7]  = '{4'd5,  5'd7,  5'd8,  5'd9,  26'd0,        1'b1, 32'h8A09_0107};
        vecs[8]  = '{4'd6,  5'd31, 5'd31, 5'd31, 26'd0,        1'b1, 32'hAA1F_03FF};
        vecs[9]  = '{4'd1,  5'd1,  5'd2,  5'd0,  26'h3FF,      1'b1, 32'hF81F_F041};
        vecs[10] = '{4'd3,  5'd0,  5'd0,  5'd0,  26'h1FFF,     1'b1, 32'h913F_FC00};
        vecs[11] = '{4'd8,  5'd2,  5'd0,  5'd0,  26'h7FFFF,    1'b1, 32'hB5FF_FFE2};
        vecs[12] = '{4'd15, 5'd0,  5'd0,  5'd0,  26'd0,        1'b0, 32'h0};
        vecs[13] = '{4'd9,  5'd0,  5'd0,  5'd0,  26'd0,        1'b1, 32'h1400_0000};

        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_a.op_sel = '0; bus_a.rd = '0; bus_a.rn = '0; bus_a.rm = '0; bus_a.imm = '0;
        bus_b.in_valid = 1'b0;
        bus_b.op_sel = '0; bus_b.rd = '0; bus_b.rn = '0; bus_b.rm = '0; bus_b.imm = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus_a.in_ready, 0);
        chk("rst_we", bus_a.imem_we, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_addr", bus_a.imem_addr, 0);
        chk("rst_wdata", bus_a.imem_wdata, 0);
        chk("rst_count", count_a, 0);
        rst_n = 1'b1;

        // Idle: a valid request is not accepted before start.
        drive_a(4'd2, 5'd3, 5'd1, 5'd2, 26'd0);
        #1 chk("idle_in_ready", bus_a.in_ready, 0);
        @(posedge clk); #1;
        chk("idle_no_we", bus_a.imem_we, 0);
        chk("idle_count", count_a, 0);

        // Start cycle has priority over the pending request.
        @(negedge clk);
        start_a = 1'b1;
        #1 chk("start_in_ready", bus_a.in_ready, 0);
        @(posedge clk); #1;
        chk("start_no_we", bus_a.imem_we, 0);
        chk("start_busy", busy_a, 1);
        chk("start_count", count_a, 0);
        @(negedge clk);
        start_a = 1'b0;

        exp_addr  = 0;
        exp_err   = 1'b0;
        last_word = '0;
        for (int i = 0; i < 14; i++) begin
            drive_a(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
            #1 chk($sformatf("v%0d_in_ready", i), bus_a.in_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i), bus_a.imem_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_addr", i), bus_a.imem_addr, exp_addr);
                chk($sformatf("v%0d_wdata", i), bus_a.imem_wdata, vecs[i].word);
                last_word = vecs[i].word;
                exp_addr++;
            end else begin
                exp_err = 1'b1;
            end
            chk($sformatf("v%0d_count", i), count_a, exp_addr);
            chk($sformatf("v%0d_err", i), err_a, exp_err);
            @(negedge clk);
        end

        bus_a.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_we", bus_a.imem_we, 0);
        chk("hold_addr", bus_a.imem_addr, exp_addr - 1);
        chk("hold_wdata", bus_a.imem_wdata, last_word);

        @(negedge clk);
        drive_a(4'd10, 5'd0, 5'd0, 5'd0, 26'd0);
        @(posedge clk); #1;
        chk("halt_we", bus_a.imem_we, 1);
        chk("halt_addr", bus_a.imem_addr, exp_addr);
        chk("halt_wdata", bus_a.imem_wdata, 32'hFFE0_0000);
        chk("halt_done", done_a, 1);
        chk("halt_in_ready", bus_a.in_ready, 0);
        chk("halt_busy", busy_a, 0);
        chk("halt_count", count_a, exp_addr + 1);
        @(posedge clk); #1;
        chk("done_no_we", bus_a.imem_we, 0);
        chk("done_count", count_a, exp_addr + 1);
        chk("done_err_sticky", err_a, 1);

        // Restart, then reset in the middle of a write cycle.
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("restart_err", err_a, 0);
        chk("restart_done", done_a, 0);
        chk("restart_count", count_a, 0);
        drive_a(4'd2, 5'd3, 5'd1, 5'd2, 26'd0);
        @(posedge clk); #1;
        chk("mid_we", bus_a.imem_we, 1);
        chk("mid_addr", bus_a.imem_addr, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we", bus_a.imem_we, 0);
        chk("async_count", count_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", bus_a.in_ready, 0);
        chk("post_rst_busy", busy_a, 0);
        chk("post_rst_we", bus_a.imem_we, 0);
        @(negedge clk);
        bus_a.in_valid = 1'b0;

        // Small memory: fill to FULL.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_b(4'd2, 5'(k));
            @(posedge clk); #1;
            chk($sformatf("full%0d_we", k), bus_b.imem_we, 1);
            chk($sformatf("full%0d_addr", k), bus_b.imem_addr, k);
            chk($sformatf("full%0d_wdata", k), bus_b.imem_wdata, 32'h8B02_0020 | k);
            @(negedge clk);
        end
        chk("full_in_ready", bus_b.in_ready, 0);
        chk("full_busy", busy_b, 0);
        chk("full_count", count_b, 4);
        chk("full_done", done_b, 0);
        @(posedge clk); #1;
        chk("full_drop_we", bus_b.imem_we, 0);
        chk("full_drop_err", err_b, 1);
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk); #1;
        chk("refill_busy", busy_b, 1);
        chk("refill_count", count_b, 0);
        chk("refill_err", err_b, 0);
        chk("refill_done", done_b, 0);
        @(negedge clk);
        start_b = 1'b0;
        drive_b(4'd2, 5'd7);
        @(posedge clk); #1;
        chk("refill_we", bus_b.imem_we, 1);
        chk("refill_addr", bus_b.imem_addr, 0);
        chk("refill_wdata", bus_b.imem_wdata, 32'h8B02_0027);
        chk("refill_count1", count_b, 1);

        // HALT landing on the last address ends in DONE, not FULL.
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_b((k == 3) ? 4'd10 : 4'd2, 5'd0);
            @(negedge clk);
        end
        chk("lasthalt_addr", bus_b.imem_addr, 3);
        chk("lasthalt_wdata", bus_b.imem_wdata, 32'hFFE0_0000);
        chk("lasthalt_done", done_b, 1);
        chk("lasthalt_count", count_b, 4);
        @(posedge clk); #1;
        chk("lasthalt_no_err", err_b, 0);
        chk("lasthalt_no_we", bus_b.imem_we, 0);
        @(negedge clk);
        bus_b.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
